handshake_constant_rep: RTL and testbench

HANDSHAKE_CONSTANT_REP -- requirements
Module: handshake_constant_rep

---
 rtl/handshake_constant_rep_pkg.sv | 20 ++
 rtl/handshake_constant_rep_if.sv | 38 +++
 rtl/handshake_constant_rep.sv | 100 ++++++++++
 tb/tb_handshake_constant_rep.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/handshake_constant_rep_pkg.sv
// Shared definitions for the constant-repeat handshake block.
// Contents:
//   state_t   - two-state FSM encoding (IDLE: nothing held, EMIT: token held)
//   cnt_width - width of a counter able to hold the value n
package handshake_constant_rep_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Bits needed for a counter holding 0..n, i.e. ceil(log2(n+1)).
  // Never returns less than 1 so a vector of this width is always legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/handshake_constant_rep_if.sv
// Handshake bundle for handshake_constant_rep.
// Signals:
//   ctrl_valid / ctrl_ready          - trigger token channel into the block
//   outs / outs_valid / outs_ready   - output token channel out of the block
//   outs_last                        - marks the final token of a group
// Modports:
//   master - the environment (drives ctrl_valid and outs_ready)
//   slave  - the block itself
interface handshake_constant_rep_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  outs_last;

  modport master (
    output ctrl_valid,
    output outs_ready,
    input  ctrl_ready,
    input  outs,
    input  outs_valid,
    input  outs_last
  );

  modport slave (
    input  ctrl_valid,
    input  outs_ready,
    output ctrl_ready,
    output outs,
    output outs_valid,
    output outs_last
  );

endinterface

// File: rtl/handshake_constant_rep.sv
// handshake_constant_rep: for every accepted ctrl token, emits REPEAT tokens
// CONST_VALUE + k*STEP (k = 0..REPEAT-1, modulo 2^DATA_WIDTH) on a
// valid/ready output channel, flagging the final one with outs_last.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - slave side of handshake_constant_rep_if (ctrl and outs channels)
// outs, outs_valid and outs_last come straight from flops; ctrl_ready is
// combinational so a new group can be accepted on the same cycle the last
// token of the current group leaves, giving back-to-back groups.
module handshake_constant_rep
  import handshake_constant_rep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CONST_VALUE = 0,
  parameter int unsigned REPEAT      = 1,
  parameter int unsigned STEP        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_constant_rep_if.slave bus
);

  localparam int unsigned           CW     = cnt_width(REPEAT);
  localparam logic [CW-1:0]         K_LAST = CW'(REPEAT - 1);
  localparam logic [DATA_WIDTH-1:0] BASE   = DATA_WIDTH'(CONST_VALUE);
  localparam logic [DATA_WIDTH-1:0] INCR   = DATA_WIDTH'(STEP);

  state_t                state_q, state_d;
  logic [CW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic                  last_q, last_d;

  logic out_fire;
  logic is_last;
  logic ctrl_ready;
  logic ctrl_fire;

  always_comb begin
    out_fire   = (state_q == EMIT) && bus.outs_ready;
    is_last    = (k_q == K_LAST);
    ctrl_ready = (state_q == IDLE) || (out_fire && is_last);
    ctrl_fire  = bus.ctrl_valid && ctrl_ready;

    state_d = state_q;
    k_d     = k_q;
    outs_d  = outs_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (ctrl_fire) begin
          state_d = EMIT;
          k_d     = '0;
          outs_d  = BASE;
          last_d  = (K_LAST == '0);
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (!is_last) begin
            k_d    = k_q + CW'(1);
            outs_d = outs_q + INCR;
            last_d = ((k_q + CW'(1)) == K_LAST);
          end else if (ctrl_fire) begin
            // Group boundary with a waiting trigger: reload without a bubble.
            k_d    = '0;
            outs_d = BASE;
            last_d = (K_LAST == '0);
          end else begin
            state_d = IDLE;
            k_d     = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      outs_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      outs_q  <= outs_d;
      last_q  <= last_d;
    end
  end

  assign bus.ctrl_ready = ctrl_ready;
  assign bus.outs       = outs_q;
  assign bus.outs_valid = (state_q == EMIT);
  assign bus.outs_last  = last_q;

endmodule

// File: tb/tb_handshake_constant_rep.sv
// Testbench for handshake_constant_rep. Three instances with different
// parameter sets share one clock and reset:
//   0: W=8 CONST=0x05 STEP=2 REPEAT=3
//   1: W=8 CONST=0xFE STEP=1 REPEAT=4
//   2: W=8 CONST=0x2A STEP=0 REPEAT=1
// The reference model is a per-instance queue of outstanding tokens: an
// accepted trigger appends the whole group, an output transfer removes the
// head. Expected outs_valid / ctrl_ready follow from how many tokens remain.
module tb_handshake_constant_rep;

  localparam int unsigned C_VAL [3] = '{32'h05, 32'hFE, 32'h2A};
  localparam int unsigned S_VAL [3] = '{2, 1, 0};
  localparam int unsigned R_VAL [3] = '{3, 4, 1};

  logic clk;
  logic rst;
  logic cv   [3];
  logic ordy [3];

  int n_checks;
  int n_fail;
  int acc_cnt [3];
  int tok_cnt [3];

  int exp_val  [3][$];
  int exp_last [3][$];

  handshake_constant_rep_if #(.DATA_WIDTH(8)) if0 ();
  handshake_constant_rep_if #(.DATA_WIDTH(8)) if1 ();
  handshake_constant_rep_if #(.DATA_WIDTH(8)) if2 ();

  assign if0.ctrl_valid = cv[0];
  assign if1.ctrl_valid = cv[1];
  assign if2.ctrl_valid = cv[2];
  assign if0.outs_ready = ordy[0];
  assign if1.outs_ready = ordy[1];
  assign if2.outs_ready = ordy[2];

  handshake_constant_rep #(.DATA_WIDTH(8), .CONST_VALUE(32'h05), .REPEAT(3), .STEP(2))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  handshake_constant_rep #(.DATA_WIDTH(8), .CONST_VALUE(32'hFE), .REPEAT(4), .STEP(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  handshake_constant_rep #(.DATA_WIDTH(8), .CONST_VALUE(32'h2A), .REPEAT(1), .STEP(0))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    for (int i = 0; i < 3; i++) begin
      exp_val[i].delete();
      exp_last[i].delete();
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, compares the presented
  // token with the head of the expected queue and appends whole groups for
  // accepted triggers.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        automatic logic       v  = 1'b0;
        automatic logic       cr = 1'b0;
        automatic logic       l  = 1'b0;
        automatic logic [7:0] o  = '0;
        automatic int         n;
        automatic logic       exp_rdy;
        case (i)
          0: begin v = if0.outs_valid; cr = if0.ctrl_ready; l = if0.outs_last; o = if0.outs; end
          1: begin v = if1.outs_valid; cr = if1.ctrl_ready; l = if1.outs_last; o = if1.outs; end
          default: begin v = if2.outs_valid; cr = if2.ctrl_ready; l = if2.outs_last; o = if2.outs; end
        endcase
        n       = exp_val[i].size();
        exp_rdy = (n == 0) || (n == 1 && ordy[i]);
        check_output($sformatf("outs_valid[%0d]", i), int'(v), int'(n > 0));
        check_output($sformatf("ctrl_ready[%0d]", i), int'(cr), int'(exp_rdy));
        if (n > 0 && v) begin
          check_output($sformatf("outs[%0d]", i), int'(o), exp_val[i][0]);
          check_output($sformatf("outs_last[%0d]", i), int'(l), exp_last[i][0]);
          if (ordy[i]) begin
            void'(exp_val[i].pop_front());
            void'(exp_last[i].pop_front());
            tok_cnt[i]++;
          end
        end
        if (cv[i] && exp_rdy) begin
          acc_cnt[i]++;
          for (int k = 0; k < int'(R_VAL[i]); k++) begin
            exp_val[i].push_back(int'((C_VAL[i] + k * S_VAL[i]) & 32'hFF));
            exp_last[i].push_back(int'(k == int'(R_VAL[i]) - 1));
          end
        end
      end
    end
  end

  task automatic apply_stimulus();
    // Single group, consumer always ready.
    ordy[0] = 1'b1;
    cv[0] = 1'b1; step(1); cv[0] = 1'b0;
    step(5);

    // Back-pressure for four cycles once the second token is showing.
    cv[0] = 1'b1; step(1); cv[0] = 1'b0;
    step(1);
    ordy[0] = 1'b0; step(4); ordy[0] = 1'b1;
    step(5);

    // Trigger held high: back-to-back groups with no bubble.
    cv[0] = 1'b1; step(9); cv[0] = 1'b0;
    step(5);

    // Wrap-around group on instance 1.
    ordy[1] = 1'b1;
    cv[1] = 1'b1; step(1); cv[1] = 1'b0;
    step(7);

    // Asynchronous reset in the middle of a group on instance 0.
    cv[0] = 1'b1; step(1); cv[0] = 1'b0;
    step(1);
    check_output("pre_reset_outs", int'(if0.outs), 32'h07);
    #1 rst = 1'b0;
    #1;
    check_output("mid_reset_outs", int'(if0.outs), 0);
    check_output("mid_reset_valid", int'(if0.outs_valid), 0);
    check_output("mid_reset_last", int'(if0.outs_last), 0);
    flush_model();
    @(posedge clk); #1 rst = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      acc_cnt[i] = 0;
      tok_cnt[i] = 0;
    end
    cv[0] = 1'b1; step(1); cv[0] = 1'b0;
    step(5);

    // Random trigger and back-pressure on all instances.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        cv[i]   = ($urandom_range(0, 1) == 1);
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      step(1);
    end
    for (int i = 0; i < 3; i++) begin
      cv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    step(12);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cv[i]      = 1'b0;
      ordy[i]    = 1'b1;
      acc_cnt[i] = 0;
      tok_cnt[i] = 0;
    end
    #2;
    check_output("reset_outs0", int'(if0.outs), 0);
    check_output("reset_valid0", int'(if0.outs_valid), 0);
    check_output("reset_last0", int'(if0.outs_last), 0);
    check_output("reset_outs1", int'(if1.outs), 0);
    check_output("reset_valid1", int'(if1.outs_valid), 0);
    check_output("reset_outs2", int'(if2.outs), 0);
    check_output("reset_valid2", int'(if2.outs_valid), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step(1);

    apply_stimulus();

    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("drained[%0d]", i), exp_val[i].size(), 0);
      check_output($sformatf("token_count[%0d]", i), tok_cnt[i], acc_cnt[i] * int'(R_VAL[i]));
    end
    check_output("random_triggers_seen", int'(acc_cnt[2] > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
